// File: rtl/uart_baud_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_chan / uart_baud_gen_frac
//  Purpose  : Fractional-N baud tick generator for the UART RX and TX paths.
//             Each channel divides clk by DIV_INT + DIV_FRAC/2^FRAC_W using a
//             fractional accumulator.
//             RX gets a one-cycle strobe per oversample tick.
//             TX gets a one-cycle strobe every OVERSAMPLE ticks.
//  Ports    : clk, rst (async, active high)
//             rx_active, tx_active  : per-channel run enables
//             div_int, div_frac     : requested divisor
//             div_load              : capture request
//             div_err               : pulse when a load is rejected (div_int < 2)
//             baud_en_rx            : RX oversample strobe
//             baud_en_tx            : TX bit strobe
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One divider channel.
// o_last is high during the final clock of each interval.
// The parent registers o_last into the strobes.
// ----------------------------------------------------------------------------
module uart_baud_chan #(
    parameter int                INT_W    = 16,
    parameter int                FRAC_W   = 4,
    parameter logic [INT_W-1:0]  DEF_INT  = '0,
    parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active,
    input  logic              i_load_ok,
    input  logic [INT_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic [INT_W-1:0]  i_sh_int,
    input  logic [FRAC_W-1:0] i_sh_frac,
    output logic              o_last
);

    // r_cnt holds the clocks remaining in the current interval.
    // A value of 0 means the channel is idle, or that a new interval starts on this edge.
    logic [INT_W:0]    r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic [INT_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic              r_pend;

    logic [INT_W-1:0]  w_sel_int;
    logic [FRAC_W-1:0] w_sel_frac;
    logic [FRAC_W:0]   w_acc_n;
    logic [INT_W:0]    w_len_m1;
    logic              w_start;

    // Divisor for an interval that starts on this edge.
    // A load arriving on this very edge takes priority over a pending shadow value.
    // A pending shadow value takes priority over the current divisor.
    always_comb begin
        w_sel_int  = r_act_int;
        w_sel_frac = r_act_frac;
        if (i_load_ok) begin
            w_sel_int  = i_div_int;
            w_sel_frac = i_div_frac;
        end else if (r_pend) begin
            w_sel_int  = i_sh_int;
            w_sel_frac = i_sh_frac;
        end
    end

    assign w_acc_n  = {1'b0, r_acc} + {1'b0, w_sel_frac};
    // Interval length is int + carry; the counter is loaded with length-1.
    assign w_len_m1 = {1'b0, w_sel_int} + {{INT_W{1'b0}}, w_acc_n[FRAC_W]}
                    - {{INT_W{1'b0}}, 1'b1};
    assign w_start  = i_active && (r_cnt == '0);
    assign o_last   = i_active && (r_cnt == {{INT_W{1'b0}}, 1'b1});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_act_int  <= DEF_INT;
            r_act_frac <= DEF_FRAC;
            r_pend     <= 1'b0;
        end else if (!i_active) begin
            // Idle: clean phase; any new or pending divisor is adopted at once.
            r_cnt      <= '0;
            r_acc      <= '0;
            r_act_int  <= w_sel_int;
            r_act_frac <= w_sel_frac;
            r_pend     <= 1'b0;
        end else if (w_start) begin
            r_cnt      <= w_len_m1;
            r_acc      <= w_acc_n[FRAC_W-1:0];
            r_act_int  <= w_sel_int;
            r_act_frac <= w_sel_frac;
            r_pend     <= 1'b0;
        end else begin
            // Mid-interval: finish with the old divisor.
            // Flag any new load for the next interval.
            r_cnt <= r_cnt - (INT_W+1)'(1);
            if (i_load_ok) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// ----------------------------------------------------------------------------
// Top level: shared shadow divisor, two channels, TX tick counter.
// ----------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_BAUD = 9600,
    parameter int INT_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_active,
    input  logic              tx_active,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_err,
    output logic              baud_en_rx,
    output logic              baud_en_tx
);

    // Reset divisor in fixed point: (CLK_FREQ * 2^FRAC_W) / (OVERSAMPLE * BAUD).
    localparam logic [63:0] c_def_div =
        (64'(CLK_FREQ) << FRAC_W) / 64'(OVERSAMPLE * DEFAULT_BAUD);
    localparam logic [INT_W-1:0]  c_def_int  = c_def_div[FRAC_W +: INT_W];
    localparam logic [FRAC_W-1:0] c_def_frac = c_def_div[FRAC_W-1:0];
    localparam int                c_tick_w   = $clog2(OVERSAMPLE);
    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(OVERSAMPLE - 1);

    logic [INT_W-1:0]    r_sh_int;
    logic [FRAC_W-1:0]   r_sh_frac;
    logic                r_div_err;
    logic                r_baud_rx;
    logic                r_baud_tx;
    logic [c_tick_w-1:0] r_tick;

    logic                w_load_ok;
    logic [1:0]          w_active;
    logic [1:0]          w_last;

    assign w_load_ok = div_load && (div_int >= INT_W'(2));
    assign w_active  = {tx_active, rx_active};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_int  <= c_def_int;
            r_sh_frac <= c_def_frac;
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= div_load && !w_load_ok;
            if (w_load_ok) begin
                r_sh_int  <= div_int;
                r_sh_frac <= div_frac;
            end
        end
    end

    // Channel 0 = RX, channel 1 = TX.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        uart_baud_chan #(
            .INT_W    (INT_W),
            .FRAC_W   (FRAC_W),
            .DEF_INT  (c_def_int),
            .DEF_FRAC (c_def_frac)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_active   (w_active[g]),
            .i_load_ok  (w_load_ok),
            .i_div_int  (div_int),
            .i_div_frac (div_frac),
            .i_sh_int   (r_sh_int),
            .i_sh_frac  (r_sh_frac),
            .o_last     (w_last[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_rx <= 1'b0;
            r_baud_tx <= 1'b0;
            r_tick    <= '0;
        end else begin
            r_baud_rx <= w_last[0];
            if (!tx_active) begin
                r_baud_tx <= 1'b0;
                r_tick    <= '0;
            end else begin
                // The TX bit strobe coincides with the sample tick that completes count OVERSAMPLE-1.
                r_baud_tx <= w_last[1] && (r_tick == c_tick_max);
                if (w_last[1]) begin
                    r_tick <= (r_tick == c_tick_max) ? '0 : r_tick + c_tick_w'(1);
                end
            end
        end
    end

    assign div_err    = r_div_err;
    assign baud_en_rx = r_baud_rx;
    assign baud_en_tx = r_baud_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_baud_gen_frac
//  Purpose  : Self-checking bench for uart_baud_gen_frac.
//             Stimulus pushes the expected strobe cycle numbers into queues.
//             A negedge monitor pops and compares each strobe the DUT produces.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_baud_gen_frac;

    localparam int INT_W  = 16;
    localparam int FRAC_W = 4;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              rx_active = 1'b0;
    logic              tx_active = 1'b0;
    logic [INT_W-1:0]  div_int   = '0;
    logic [FRAC_W-1:0] div_frac  = '0;
    logic              div_load  = 1'b0;
    logic              div_err;
    logic              baud_en_rx;
    logic              baud_en_tx;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    int q_rx[$];
    int q_tx[$];
    int q_err[$];

    uart_baud_gen_frac #(
        .CLK_FREQ     (100_000_000),
        .OVERSAMPLE   (16),
        .DEFAULT_BAUD (9600),
        .INT_W        (INT_W),
        .FRAC_W       (FRAC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_active  (rx_active),
        .tx_active  (tx_active),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_load   (div_load),
        .div_err    (div_err),
        .baud_en_rx (baud_en_rx),
        .baud_en_tx (baud_en_tx)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far.
    // A strobe registered on edge E is observed at the negedge where cyc == E.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (baud_en_rx) begin
                if (q_rx.size() == 0) check("rx_unexpected_strobe", cyc, -1);
                else                  check("rx_strobe_cycle", cyc, q_rx.pop_front());
            end
            if (baud_en_tx) begin
                if (q_tx.size() == 0) check("tx_unexpected_strobe", cyc, -1);
                else                  check("tx_strobe_cycle", cyc, q_tx.pop_front());
            end
            if (div_err) begin
                if (q_err.size() == 0) check("err_unexpected_pulse", cyc, -1);
                else                   check("err_pulse_cycle", cyc, q_err.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive a load at the current negedge; it is sampled on the next rising edge.
    task automatic pulse_load(input int i, input int f);
        div_int  = INT_W'(i);
        div_frac = FRAC_W'(f);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, t4, t5, t6, t7;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_baud_en_rx", baud_en_rx, 0);
        check("reset_baud_en_tx", baud_en_tx, 0);
        check("reset_div_err",    div_err,    0);
        rst = 1'b0;
        @(negedge clk);

        // Divisor 10 and a pending load of 7, discarded by an async reset
        pulse_load(10, 0);
        t0 = cyc;
        rx_active = 1'b1;
        q_rx.push_back(t0 + 10);
        q_rx.push_back(t0 + 20);
        q_rx.push_back(t0 + 30);
        wait_cyc(t0 + 23);
        pulse_load(7, 0);
        wait_cyc(t0 + 30);
        check("rx_high_before_rst", baud_en_rx, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_baud_en_rx", baud_en_rx, 0);
        check("async_rst_baud_en_tx", baud_en_tx, 0);
        check("async_rst_div_err",    div_err,    0);
        rx_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // After reset the default divisor 651 is in effect
        t1 = cyc;
        rx_active = 1'b1;
        q_rx.push_back(t1 + 651);
        q_rx.push_back(t1 + 1302);
        wait_cyc(t1 + 1302);
        rx_active = 1'b0;
        @(negedge clk);

        // Fractional 4 + 8/16: RX intervals 4,5,...; TX bit every 72 clocks
        pulse_load(4, 8);
        t2 = cyc;
        rx_active = 1'b1;
        tx_active = 1'b1;
        for (int m = 1; m <= 9; m++) begin
            q_rx.push_back(t2 + 9*m - 5);
            q_rx.push_back(t2 + 9*m);
        end
        q_tx.push_back(t2 + 72);
        q_tx.push_back(t2 + 144);
        // Abort RX mid-interval; TX keeps running
        wait_cyc(t2 + 83);
        rx_active = 1'b0;
        // Restart RX from a clean phase
        wait_cyc(t2 + 100);
        t3 = cyc;
        rx_active = 1'b1;
        q_rx.push_back(t3 + 4);
        q_rx.push_back(t3 + 9);
        wait_cyc(t3 + 9);
        rx_active = 1'b0;
        wait_cyc(t2 + 144);
        tx_active = 1'b0;
        @(negedge clk);

        // Load while running: 10 -> 6 mid-interval, then 6 -> 3 coincident with a strobe
        pulse_load(10, 0);
        t4 = cyc;
        rx_active = 1'b1;
        q_rx.push_back(t4 + 10);
        q_rx.push_back(t4 + 20);
        q_rx.push_back(t4 + 26);
        q_rx.push_back(t4 + 32);
        q_rx.push_back(t4 + 35);
        q_rx.push_back(t4 + 38);
        wait_cyc(t4 + 12);
        pulse_load(6, 0);
        wait_cyc(t4 + 32);
        pulse_load(3, 0);
        wait_cyc(t4 + 38);
        rx_active = 1'b0;
        @(negedge clk);

        // Rejected loads (div_int 1 and 0) leave the spacing of 3 unchanged
        t5 = cyc;
        rx_active = 1'b1;
        for (int k = 1; k <= 5; k++) q_rx.push_back(t5 + 3*k);
        wait_cyc(t5 + 4);
        q_err.push_back(t5 + 5);
        pulse_load(1, 0);
        wait_cyc(t5 + 7);
        q_err.push_back(t5 + 8);
        pulse_load(0, 5);
        wait_cyc(t5 + 15);
        rx_active = 1'b0;
        @(negedge clk);

        // Minimum legal divisor 2
        pulse_load(2, 0);
        t6 = cyc;
        rx_active = 1'b1;
        for (int k = 1; k <= 4; k++) q_rx.push_back(t6 + 2*k);
        wait_cyc(t6 + 8);
        rx_active = 1'b0;
        @(negedge clk);

        // Back-to-back loads 8 then 12 in one interval: only 12 is ever used
        pulse_load(20, 0);
        t7 = cyc;
        rx_active = 1'b1;
        q_rx.push_back(t7 + 20);
        q_rx.push_back(t7 + 40);
        q_rx.push_back(t7 + 52);
        q_rx.push_back(t7 + 64);
        wait_cyc(t7 + 22);
        pulse_load(8, 0);
        pulse_load(12, 0);
        wait_cyc(t7 + 64);
        rx_active = 1'b0;

        repeat (40) @(negedge clk);
        check("rx_expected_left",  q_rx.size(),  0);
        check("tx_expected_left",  q_tx.size(),  0);
        check("err_expected_left", q_err.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
